// File: rtl/qpu_exu_timing_queue_pkg.sv
// Shared constants and small types for the QPU EXU timing queue.
// The default widths match the QPU timeline, queue and event-payload sizes.
package qpu_exu_timing_queue_pkg;

  // Width of the timeline counter, the timepoint label and event stamps
  localparam int QPU_TIME_WIDTH = 32;
  // Number of timing-queue entries (power of two, at least 2)
  localparam int QPU_TQ_DEPTH   = 8;
  // Quantum event payload: {opcode2[8:0], opcode1[8:0]}
  localparam int QPU_QEVT_WIDTH = 18;

  // Width of the pre-interval field carried by quantum ops
  localparam int QPU_PI_WIDTH   = 3;

  // Kind of request arriving from the EXU
  typedef enum logic {
    REQ_OP    = 1'b0,
    REQ_QWAIT = 1'b1
  } req_kind_e;

endpackage

// File: rtl/qpu_exu_timing_queue_fifo.sv
// Synchronous FIFO holding {stamp, event} records for the timing queue.
// The head entry is a plain register read, so a push becomes visible at the
// head on the cycle after it is written. Flush empties the queue in one cycle.
module qpu_tq_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & ~empty & ~flush;
  assign head_data = mem[rd_ptr];

  // Storage array; cleared on reset so the head reads zero until first written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qpu_exu_timing_queue.sv
// Timing scheduler between the QPU EXU dispatch path and the quantum control
// interface. QWAITs and op pre-intervals advance a timepoint label; every
// quantum op is stamped with that label, queued, and released when the free
// running timeline reaches its stamp. Events that leave after their stamp
// raise a sticky late flag.
module qpu_exu_timing_queue
  import qpu_exu_timing_queue_pkg::*;
#(
  parameter int TIME_W = QPU_TIME_WIDTH,
  parameter int DEPTH  = QPU_TQ_DEPTH,
  parameter int EVT_W  = QPU_QEVT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_run,
  input  logic                     i_clr,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_qwait,
  input  logic [TIME_W-1:0]        i_wait,
  input  logic [QPU_PI_WIDTH-1:0]  i_pi,
  input  logic [EVT_W-1:0]         i_evt,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [EVT_W-1:0]         o_evt,
  output logic [TIME_W-1:0]        o_time,
  output logic [TIME_W-1:0]        o_tl,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_late
);

  localparam int ENTRY_W = TIME_W + EVT_W;

  req_kind_e             req_kind;
  logic [TIME_W-1:0]     tl;
  logic [TIME_W-1:0]     label;
  logic [TIME_W-1:0]     stamp;
  logic [TIME_W-1:0]     head_stamp;
  logic [EVT_W-1:0]      head_evt;
  logic [TIME_W-1:0]     tl_minus_stamp;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  due;

  assign req_kind = i_qwait ? REQ_QWAIT : REQ_OP;

  // Stamp for an incoming op: current label plus its zero-extended pre-interval
  assign stamp = label + TIME_W'(i_pi);

  // QWAITs never occupy an entry, so they are accepted even when the queue is
  // full; a pop in the same cycle does not open a slot for an op
  assign i_ready = ~i_clr & ((req_kind == REQ_QWAIT) | ~fifo_full);
  assign accept  = i_valid & i_ready;
  assign push    = accept & (req_kind == REQ_OP);

  // Wrap-safe due test: head is due once tl - stamp is non-negative as signed
  assign tl_minus_stamp = tl - head_stamp;
  assign due            = ~fifo_empty & ~tl_minus_stamp[TIME_W-1];

  assign o_valid = i_run & due & ~i_clr;
  assign pop     = o_valid & o_ready;

  assign head_stamp = head_entry[ENTRY_W-1:EVT_W];
  assign head_evt   = head_entry[EVT_W-1:0];
  assign o_time     = head_stamp;
  assign o_evt      = head_evt;
  assign o_tl       = tl;

  qpu_tq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (i_clr),
    .push      (push),
    .pop       (pop),
    .push_data ({stamp, i_evt}),
    .head_data (head_entry),
    .count     (o_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Timeline counter: advances while running, wraps silently, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tl <= '0;
    end else if (i_clr) begin
      tl <= '0;
    end else if (i_run) begin
      tl <= tl + TIME_W'(1);
    end
  end

  // Timepoint label: QWAIT adds its wait, an op moves the label to its stamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      label <= '0;
    end else if (i_clr) begin
      label <= '0;
    end else if (accept) begin
      if (req_kind == REQ_QWAIT) begin
        label <= label + i_wait;
      end else begin
        label <= stamp;
      end
    end
  end

  // Sticky late flag: set whenever an event leaves in a cycle other than its stamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_late <= 1'b0;
    end else if (i_clr) begin
      o_late <= 1'b0;
    end else if (pop && (tl != head_stamp)) begin
      o_late <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qpu_exu_timing_queue.sv
// Directed bench for the QPU EXU timing queue. Uses an 8-bit timeline so
// wrap-around can be reached in a few hundred cycles.
module tb_qpu_exu_timing_queue;

  localparam int TW    = 8;
  localparam int DEPTH = 8;
  localparam int EW    = 18;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_run = 1'b0;
  logic          i_clr = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          i_qwait = 1'b0;
  logic [TW-1:0] i_wait = '0;
  logic [2:0]    i_pi = '0;
  logic [EW-1:0] i_evt = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [EW-1:0] o_evt;
  logic [TW-1:0] o_time;
  logic [TW-1:0] o_tl;
  logic [CW-1:0] o_cnt;
  logic          o_late;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          qwait;
    logic [TW-1:0] wait_cycles;
    logic [2:0]    pi;
    logic [EW-1:0] evt;
    logic [TW-1:0] exp_time;
  } vec_t;

  vec_t vecs[9];

  qpu_exu_timing_queue #(
    .TIME_W (TW),
    .DEPTH  (DEPTH),
    .EVT_W  (EW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_run   (i_run),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_qwait (i_qwait),
    .i_wait  (i_wait),
    .i_pi    (i_pi),
    .i_evt   (i_evt),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_evt   (o_evt),
    .o_time  (o_time),
    .o_tl    (o_tl),
    .o_cnt   (o_cnt),
    .o_late  (o_late)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One request for one cycle, driven at negedge and dropped just after posedge
  task automatic apply_stimulus(input logic qwait, input logic [TW-1:0] wcyc,
                                input logic [2:0] pi, input logic [EW-1:0] evt);
    @(negedge clk);
    i_valid = 1'b1;
    i_qwait = qwait;
    i_wait  = wcyc;
    i_pi    = pi;
    i_evt   = evt;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_qwait = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    i_clr = 1'b1;
    #1;
    check_output("clr_ready", 32'(i_ready), 32'd0);
    check_output("clr_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    i_clr = 1'b0;
  endtask

  // Wait (bounded) for the next issued event and compare its timing and payload
  task automatic wait_issue(input string name, input logic [TW-1:0] exp_time,
                            input logic [TW-1:0] exp_tl, input logic [EW-1:0] exp_evt);
    bit found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (o_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: no o_valid within 300 cycles, expected stamp %0d", name, exp_time);
    end else begin
      check_output({name, "_tl"},   32'(o_tl),   32'(exp_tl));
      check_output({name, "_time"}, 32'(o_time), 32'(exp_time));
      check_output({name, "_evt"},  32'(o_evt),  32'(exp_evt));
    end
  endtask

  initial begin
    // Label arithmetic table: expected stamps computed by hand from label 0
    vecs[0] = '{1'b1, 8'd3,  3'd0, 18'h00000, 8'd0};
    vecs[1] = '{1'b0, 8'd0,  3'd1, 18'h00111, 8'd4};
    vecs[2] = '{1'b1, 8'd0,  3'd0, 18'h00000, 8'd0};
    vecs[3] = '{1'b0, 8'd0,  3'd7, 18'h00222, 8'd11};
    vecs[4] = '{1'b1, 8'd20, 3'd0, 18'h00000, 8'd0};
    vecs[5] = '{1'b0, 8'd0,  3'd2, 18'h00333, 8'd33};
    vecs[6] = '{1'b0, 8'd0,  3'd5, 18'h3FFFF, 8'd38};
    vecs[7] = '{1'b1, 8'd1,  3'd0, 18'h00000, 8'd0};
    vecs[8] = '{1'b0, 8'd0,  3'd3, 18'h20001, 8'd42};

    // Reset state
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_ready", 32'(i_ready), 32'd1);
    check_output("rst_valid", 32'(o_valid), 32'd0);
    check_output("rst_cnt",   32'(o_cnt),   32'd0);
    check_output("rst_tl",    32'(o_tl),    32'd0);
    check_output("rst_late",  32'(o_late),  32'd0);
    check_output("rst_evt",   32'(o_evt),   32'd0);
    check_output("rst_time",  32'(o_time),  32'd0);

    // Op with pi=3 at tl=0 issues exactly at tl=3
    o_ready = 1'b1;
    @(negedge clk);
    i_run   = 1'b1;
    i_valid = 1'b1;
    i_qwait = 1'b0;
    i_pi    = 3'd3;
    i_evt   = 18'h0ABCD;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_issue("t1", 8'd3, 8'd3, 18'h0ABCD);
    @(posedge clk);
    #1;
    check_output("t1_late", 32'(o_late), 32'd0);

    // Table-driven label arithmetic, pushed while the timeline is paused
    i_run = 1'b0;
    clear_pulse();
    for (int v = 0; v < 9; v++) begin
      apply_stimulus(vecs[v].qwait, vecs[v].wait_cycles, vecs[v].pi, vecs[v].evt);
    end
    check_output("tab_cnt", 32'(o_cnt), 32'd5);
    i_run = 1'b1;
    for (int v = 0; v < 9; v++) begin
      if (!vecs[v].qwait) begin
        wait_issue($sformatf("tab%0d", v), vecs[v].exp_time, vecs[v].exp_time, vecs[v].evt);
      end
    end
    @(posedge clk);
    #1;
    check_output("tab_late", 32'(o_late), 32'd0);
    check_output("tab_cnt_empty", 32'(o_cnt), 32'd0);

    // Shared timepoint: stamps 10,10,12 issue at tl 10,11,12 and flag late
    clear_pulse();
    apply_stimulus(1'b1, 8'd10, 3'd0, 18'h0);
    apply_stimulus(1'b0, 8'd0, 3'd0, 18'h00A01);
    apply_stimulus(1'b0, 8'd0, 3'd0, 18'h00A02);
    apply_stimulus(1'b0, 8'd0, 3'd2, 18'h00C03);
    wait_issue("t2a", 8'd10, 8'd10, 18'h00A01);
    @(posedge clk);
    #1;
    check_output("t2a_late", 32'(o_late), 32'd0);
    wait_issue("t2b", 8'd10, 8'd11, 18'h00A02);
    wait_issue("t2c", 8'd12, 8'd12, 18'h00C03);
    @(posedge clk);
    #1;
    check_output("t2_late", 32'(o_late), 32'd1);

    // Fill the queue: ops refused, QWAIT still accepted, no bypass on pop
    i_run = 1'b0;
    clear_pulse();
    for (int k = 0; k < DEPTH; k++) begin
      apply_stimulus(1'b0, 8'd0, 3'd7, 18'(k + 16'h100));
    end
    check_output("t3_full_cnt", 32'(o_cnt), 32'(DEPTH));
    @(negedge clk);
    i_valid = 1'b1;
    i_qwait = 1'b0;
    i_pi    = 3'd1;
    #1;
    check_output("t3_op_ready", 32'(i_ready), 32'd0);
    i_qwait = 1'b1;
    i_wait  = 8'd5;
    #1;
    check_output("t3_qwait_ready", 32'(i_ready), 32'd1);
    @(posedge clk);
    #1;
    i_qwait = 1'b0;
    i_pi    = 3'd0;
    check_output("t3_cnt_after_qwait", 32'(o_cnt), 32'(DEPTH));
    i_run = 1'b1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        #1;
        if (o_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("[TB] FAIL t3_pop_timeout: no o_valid while full, expected stamp 7");
      end else begin
        check_output("t3_nobypass_ready", 32'(i_ready), 32'd0);
        check_output("t3_head_time", 32'(o_time), 32'd7);
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check_output("t3_cnt_after_pop", 32'(o_cnt), 32'(DEPTH - 1));
    begin
      bit drained = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (o_cnt == '0) begin
          drained = 1'b1;
          break;
        end
      end
      check_output("t3_drained", 32'(drained), 32'd1);
    end

    // Backpressure past stamp 5, release at tl=8
    o_ready = 1'b0;
    clear_pulse();
    apply_stimulus(1'b0, 8'd0, 3'd5, 18'h15555);
    begin
      bit released = 1'b0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (o_tl == 8'd6) begin
          #1;
          check_output("t4_held_valid", 32'(o_valid), 32'd1);
          check_output("t4_held_cnt", 32'(o_cnt), 32'd1);
        end else if (o_tl == 8'd8) begin
          o_ready = 1'b1;
          #1;
          check_output("t4_valid", 32'(o_valid), 32'd1);
          check_output("t4_time", 32'(o_time), 32'd5);
          check_output("t4_evt", 32'(o_evt), 32'h15555);
          check_output("t4_late_before", 32'(o_late), 32'd0);
          @(posedge clk);
          #1;
          check_output("t4_late", 32'(o_late), 32'd1);
          check_output("t4_cnt", 32'(o_cnt), 32'd0);
          released = 1'b1;
          break;
        end
      end
      check_output("t4_released", 32'(released), 32'd1);
    end

    // Three entries queued, then clear; the next op stamps from zero
    @(negedge clk);
    i_run = 1'b0;
    apply_stimulus(1'b0, 8'd0, 3'd1, 18'h00061);
    apply_stimulus(1'b0, 8'd0, 3'd2, 18'h00062);
    apply_stimulus(1'b0, 8'd0, 3'd3, 18'h00063);
    check_output("t6_cnt3", 32'(o_cnt), 32'd3);
    check_output("t6_paused_valid", 32'(o_valid), 32'd0);
    clear_pulse();
    check_output("t6_cnt0", 32'(o_cnt), 32'd0);
    check_output("t6_tl0", 32'(o_tl), 32'd0);
    check_output("t6_late0", 32'(o_late), 32'd0);
    apply_stimulus(1'b0, 8'd0, 3'd2, 18'h00064);
    i_run = 1'b1;
    wait_issue("t6", 8'd2, 8'd2, 18'h00064);

    // Stamp wraps past 2^TW: label 253 + 4 = 1, issued only after tl wraps
    clear_pulse();
    begin
      bit reached = 1'b0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        #1;
        if (o_tl == 8'd250) begin
          reached = 1'b1;
          break;
        end
      end
      check_output("t5_reach", 32'(reached), 32'd1);
    end
    apply_stimulus(1'b1, 8'd253, 3'd0, 18'h0);
    apply_stimulus(1'b0, 8'd0, 3'd4, 18'h05A5A);
    wait_issue("t5", 8'd1, 8'd1, 18'h05A5A);
    @(posedge clk);
    #1;
    check_output("t5_late", 32'(o_late), 32'd0);

    // Asynchronous reset mid-operation discards queued entries
    i_run = 1'b0;
    apply_stimulus(1'b0, 8'd0, 3'd6, 18'h00071);
    apply_stimulus(1'b0, 8'd0, 3'd6, 18'h00072);
    check_output("ar_cnt_before", 32'(o_cnt), 32'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("ar_cnt", 32'(o_cnt), 32'd0);
    check_output("ar_tl", 32'(o_tl), 32'd0);
    check_output("ar_ready", 32'(i_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
